// File: rtl/uop_cache_sdp.sv
// Micro-op cache store: simple-dual-port RAM with per-entry valid bit, registered hit/miss read,
// write-first bypass and self-sequenced invalidation sweep. Optional macro: UOP_CACHE_OUT_REG_EN.
module uop_cache_sdp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write_enable,
  input  logic [ADDR_W-1:0] write_address,
  input  logic [DATA_W-1:0] instruction,
  input  logic              read_enable,
  input  logic [ADDR_W-1:0] read_address,
  input  logic              flush,
  output logic [DATA_W-1:0] out_instruction,
  output logic              out_hit,
  output logic              rd_ack,
  output logic              busy
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {
    ST_SWEEP = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] sweep_cnt_q;

  // Valid bit lives in the MSB so one write per cycle covers both data and valid.
  logic [DATA_W:0]   mem_q [DEPTH];

  logic              idle;
  logic              wr_acc;
  logic              rd_acc;
  logic              bypass;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W:0]   mem_wdata;
  logic [DATA_W:0]   rd_word;

  logic              rd_ack_s1_q;
  logic              hit_s1_q;
  logic [DATA_W-1:0] data_s1_q;

  assign idle   = (state_q == ST_IDLE);
  assign wr_acc = write_enable && idle && !flush;
  assign rd_acc = read_enable && idle && !flush;
  assign bypass = wr_acc && (write_address == read_address);
  assign busy   = (state_q == ST_SWEEP);

  assign mem_we    = !idle || wr_acc;
  assign mem_waddr = idle ? write_address : sweep_cnt_q;
  assign mem_wdata = idle ? {1'b1, instruction} : '0;
  assign rd_word   = mem_q[read_address];

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_SWEEP;
      sweep_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_SWEEP: begin
          sweep_cnt_q <= sweep_cnt_q + 1'b1;
          if (&sweep_cnt_q) begin
            state_q <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (flush) begin
            state_q     <= ST_SWEEP;
            sweep_cnt_q <= '0;
          end
        end
        default: begin
          state_q     <= ST_SWEEP;
          sweep_cnt_q <= '0;
        end
      endcase
    end
  end

  // Hit and data hold their last value when no read is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ack_s1_q <= 1'b0;
      hit_s1_q    <= 1'b0;
      data_s1_q   <= '0;
    end else begin
      rd_ack_s1_q <= rd_acc;
      if (rd_acc) begin
        if (bypass) begin
          hit_s1_q  <= 1'b1;
          data_s1_q <= instruction;
        end else begin
          hit_s1_q  <= rd_word[DATA_W];
          data_s1_q <= rd_word[DATA_W] ? rd_word[DATA_W-1:0] : '0;
        end
      end
    end
  end

`ifdef UOP_CACHE_OUT_REG_EN
  logic              rd_ack_s2_q;
  logic              hit_s2_q;
  logic [DATA_W-1:0] data_s2_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ack_s2_q <= 1'b0;
      hit_s2_q    <= 1'b0;
      data_s2_q   <= '0;
    end else begin
      rd_ack_s2_q <= rd_ack_s1_q;
      hit_s2_q    <= hit_s1_q;
      data_s2_q   <= data_s1_q;
    end
  end

  assign rd_ack          = rd_ack_s2_q;
  assign out_hit         = hit_s2_q;
  assign out_instruction = data_s2_q;
`else
  assign rd_ack          = rd_ack_s1_q;
  assign out_hit         = hit_s1_q;
  assign out_instruction = data_s1_q;
`endif

endmodule

// File: tb/tb_uop_cache_sdp.sv
// Self-checking bench for uop_cache_sdp against a per-entry array model with a busy countdown.
module tb_uop_cache_sdp;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 6;
  localparam int DEPTH  = 1 << ADDR_W;

  // Clock / reset and DUT signals
  logic              clk = 1'b0;
  logic              reset;
  logic              write_enable;
  logic [ADDR_W-1:0] write_address;
  logic [DATA_W-1:0] instruction;
  logic              read_enable;
  logic [ADDR_W-1:0] read_address;
  logic              flush;
  logic [DATA_W-1:0] out_instruction;
  logic              out_hit;
  logic              rd_ack;
  logic              busy;

  always #5 clk = ~clk;

  uop_cache_sdp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk             (clk),
    .reset           (reset),
    .write_enable    (write_enable),
    .write_address   (write_address),
    .instruction     (instruction),
    .read_enable     (read_enable),
    .read_address    (read_address),
    .flush           (flush),
    .out_instruction (out_instruction),
    .out_hit         (out_hit),
    .rd_ack          (rd_ack),
    .busy            (busy)
  );

  // Reference model: contents, busy countdown, and response pipeline
  bit                mdl_valid [DEPTH];
  logic [DATA_W-1:0] mdl_data  [DEPTH];
  int                busy_left;
  logic              s1_ack, s1_hit, s2_ack, s2_hit;
  logic [DATA_W-1:0] s1_data, s2_data;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic mdl_clear_all();
    for (int i = 0; i < DEPTH; i++) begin
      mdl_valid[i] = 1'b0;
      mdl_data[i]  = '0;
    end
  endtask

  task automatic compare_outputs(input string where);
`ifdef UOP_CACHE_OUT_REG_EN
    check({where, ".rd_ack"}, 64'(rd_ack), 64'(s2_ack));
    check({where, ".hit"},    64'(out_hit), 64'(s2_hit));
    check({where, ".data"},   64'(out_instruction), 64'(s2_data));
`else
    check({where, ".rd_ack"}, 64'(rd_ack), 64'(s1_ack));
    check({where, ".hit"},    64'(out_hit), 64'(s1_hit));
    check({where, ".data"},   64'(out_instruction), 64'(s1_data));
`endif
    check({where, ".busy"}, 64'(busy), 64'(busy_left > 0));
  endtask

  // One clock of stimulus; inputs change #1 after the rising edge, outputs sampled #1 after the next.
  task automatic cycle(input string where, input bit we, input int wa, input logic [DATA_W-1:0] wd,
                       input bit re, input int ra, input bit fl);
    write_enable  = we;
    write_address = ADDR_W'(wa);
    instruction   = wd;
    read_enable   = re;
    read_address  = ADDR_W'(ra);
    flush         = fl;
    s2_ack  = s1_ack;
    s2_hit  = s1_hit;
    s2_data = s1_data;
    if (busy_left > 0) begin
      busy_left--;
      s1_ack = 1'b0;
    end else if (fl) begin
      mdl_clear_all();
      busy_left = DEPTH;
      s1_ack    = 1'b0;
    end else begin
      if (we) begin
        mdl_valid[wa] = 1'b1;
        mdl_data[wa]  = wd;
      end
      s1_ack = re;
      if (re) begin
        s1_hit  = mdl_valid[ra];
        s1_data = mdl_valid[ra] ? mdl_data[ra] : '0;
      end
    end
    @(posedge clk);
    #1;
    compare_outputs(where);
  endtask

  task automatic idle_cycles(input string where, input int n);
    for (int i = 0; i < n; i++) cycle(where, 1'b0, 0, '0, 1'b0, 0, 1'b0);
  endtask

  task automatic do_reset(input int hold);
    reset         = 1'b1;
    write_enable  = 1'b0;
    write_address = '0;
    instruction   = '0;
    read_enable   = 1'b0;
    read_address  = '0;
    flush         = 1'b0;
    mdl_clear_all();
    {s1_ack, s1_hit, s1_data, s2_ack, s2_hit, s2_data} = '0;
    busy_left = DEPTH;
    #1;
    compare_outputs("reset");
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      compare_outputs("reset_hold");
    end
    reset = 1'b0;
  endtask

  initial begin
    logic [DATA_W-1:0] fill [DEPTH];

    // Reset, sweep, read of never-written entry misses
    do_reset(2);
    idle_cycles("init_sweep", DEPTH);
    cycle("miss5", 1'b0, 0, '0, 1'b1, 5, 1'b0);
    idle_cycles("miss5_drain", 2);

    // Write then read next cycle
    cycle("wr12", 1'b1, 12, 32'hDEADBEEF, 1'b0, 0, 1'b0);
    cycle("rd12", 1'b0, 0, '0, 1'b1, 12, 1'b0);
    idle_cycles("rd12_drain", 2);

    // Same-cycle write/read collision
    cycle("coll63", 1'b1, 63, 32'h12345678, 1'b1, 63, 1'b0);
    idle_cycles("coll63_drain", 2);

    // Fill every entry, then back-to-back reads
    for (int a = 0; a < DEPTH; a++) begin
      fill[a] = $urandom;
      cycle("fill", 1'b1, a, fill[a], 1'b0, 0, 1'b0);
    end
    for (int a = 0; a < DEPTH; a++) cycle("b2b_rd", 1'b0, 0, '0, 1'b1, a, 1'b0);
    idle_cycles("b2b_drain", 2);

    // Flush drops same-cycle read; writes during sweep dropped; entry misses afterwards
    cycle("wr7", 1'b1, 7, 32'hA5A5_0007, 1'b0, 0, 1'b0);
    cycle("flush_rd7", 1'b0, 0, '0, 1'b1, 7, 1'b1);
    cycle("busy_wr7", 1'b1, 7, 32'h0BAD_0007, 1'b1, 7, 1'b1);
    idle_cycles("flush_sweep", DEPTH);
    cycle("rd7_after", 1'b0, 0, '0, 1'b1, 7, 1'b0);
    idle_cycles("rd7_drain", 2);

    // Reset in the middle of a sweep restarts it
    cycle("flush2", 1'b0, 0, '0, 1'b0, 0, 1'b1);
    idle_cycles("sweep30", 30);
    do_reset(1);
    idle_cycles("resweep", DEPTH);
    cycle("post_resweep_rd", 1'b0, 0, '0, 1'b1, 0, 1'b0);

    // Random traffic on a narrow address window to provoke collisions
    for (int i = 0; i < 600; i++) begin
      bit we, re, fl;
      int wa, ra, span;
      span = ($urandom_range(0, 3) == 0) ? DEPTH - 1 : 7;
      we = 1'($urandom_range(0, 1));
      re = 1'($urandom_range(0, 1));
      wa = int'($urandom_range(0, span));
      ra = int'($urandom_range(0, span));
      fl = ($urandom_range(0, 149) == 0);
      cycle("rand", we, wa, DATA_W'($urandom), re, ra, fl);
    end
    idle_cycles("final_drain", DEPTH + 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
